// File: rtl/cal_meas_unit_pkg.sv
// Shared definitions for the calibration measurement front-end.
package cal_meas_unit_pkg;

  localparam int ADC_WIDTH         = 12;
  localparam int NUM_OUTPUTS       = 2;
  localparam int CAL_SETTLE_CYCLES = 16;
  localparam int CAL_AVG_SAMPLES   = 8;
  localparam int CAL_MEAS_TIMEOUT  = 256;

  typedef enum logic [1:0] {
    MEAS_IDLE   = 2'd0,
    MEAS_SETTLE = 2'd1,
    MEAS_ACCUM  = 2'd2
  } meas_state_t;

endpackage

// File: rtl/cal_meas_unit_adc_chan_accum.sv
// Per-channel sample accumulator with a sticky full-scale hit flag.
// sum/sat_hit present the post-edge values, so they already include a sample
// accepted this cycle; the parent can latch the final average on that edge.
module adc_chan_accum #(
  parameter int ADC_WIDTH = cal_meas_unit_pkg::ADC_WIDTH,
  parameter int SUM_WIDTH = cal_meas_unit_pkg::ADC_WIDTH + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 acc_en,
  input  logic [ADC_WIDTH-1:0] sample,
  output logic [SUM_WIDTH-1:0] sum,
  output logic                 sat_hit
);

  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                 sat_q, sat_d;

  // Next sum and sticky full-scale flag.
  always_comb begin
    sum_d = sum_q;
    sat_d = sat_q;
    if (clear) begin
      sum_d = '0;
      sat_d = 1'b0;
    end else if (acc_en) begin
      sum_d = sum_q + SUM_WIDTH'(sample);
      if (sample == '1) sat_d = 1'b1;
    end
  end

  // Accumulator registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      sat_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      sat_q <= sat_d;
    end
  end

  assign sum     = sum_d;
  assign sat_hit = sat_d;

endmodule

// File: rtl/cal_meas_unit.sv
// Measurement front-end: settle wait, then average AVG_SAMPLES valid ADC
// samples per channel; reports averages with a done pulse and a sat flag.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   MEAS_IDLE   | waiting for start; outputs hold the last result
//   MEAS_SETTLE | thermal settle wait, adc_valid ignored
//   MEAS_ACCUM  | accumulating valid samples, timeout armed
module cal_meas_unit #(
  parameter int ADC_WIDTH      = cal_meas_unit_pkg::ADC_WIDTH,
  parameter int NUM_OUTPUTS    = cal_meas_unit_pkg::NUM_OUTPUTS,
  parameter int SETTLE_CYCLES  = cal_meas_unit_pkg::CAL_SETTLE_CYCLES,
  parameter int AVG_SAMPLES    = cal_meas_unit_pkg::CAL_AVG_SAMPLES,
  parameter int TIMEOUT_CYCLES = cal_meas_unit_pkg::CAL_MEAS_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             adc_valid,
  input  logic [NUM_OUTPUTS*ADC_WIDTH-1:0] adc_data,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_OUTPUTS*ADC_WIDTH-1:0] avg_data,
  output logic                             sat,
  output logic                             timeout
);
  import cal_meas_unit_pkg::*;

  localparam int LOG2_AVG = $clog2(AVG_SAMPLES);
  localparam int SUM_W    = ADC_WIDTH + LOG2_AVG;
  localparam int SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_W    = (AVG_SAMPLES > 1) ? $clog2(AVG_SAMPLES) : 1;
  localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AVG_SAMPLES - 1);

  if (AVG_SAMPLES < 1 || (AVG_SAMPLES & (AVG_SAMPLES - 1)) != 0) begin : g_bad_avg
    $error("AVG_SAMPLES must be a power of two >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  meas_state_t                      state_q, state_d;
  logic [SET_W-1:0]                 settle_q, settle_d;
  logic [CNT_W-1:0]                 samp_q, samp_d;
  logic [TMO_W-1:0]                 tmo_q, tmo_d;
  logic                             done_q, done_d;
  logic                             timeout_q, timeout_d;
  logic                             sat_q, sat_d;
  logic [NUM_OUTPUTS*ADC_WIDTH-1:0] avg_q, avg_d;

  logic                   clear_acc;
  logic                   acc_en;
  logic [SUM_W-1:0]       sum_arr [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] hit_vec;

  assign acc_en = (state_q == MEAS_ACCUM) && adc_valid;

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_chan
    adc_chan_accum #(
      .ADC_WIDTH (ADC_WIDTH),
      .SUM_WIDTH (SUM_W)
    ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear_acc),
      .acc_en  (acc_en),
      .sample  (adc_data[k*ADC_WIDTH +: ADC_WIDTH]),
      .sum     (sum_arr[k]),
      .sat_hit (hit_vec[k])
    );
  end

  // Next-state, counters and result capture. Timers are down-counters;
  // abort is checked first so it beats both completion and timeout.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    samp_d    = samp_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    sat_d     = sat_q;
    avg_d     = avg_q;
    clear_acc = 1'b0;
    case (state_q)
      MEAS_IDLE: begin
        if (start && !abort) begin
          clear_acc = 1'b1;
          samp_d    = '0;
          tmo_d     = TMO_LOAD;
          settle_d  = SET_LOAD;
          state_d   = (SETTLE_CYCLES == 0) ? MEAS_ACCUM : MEAS_SETTLE;
        end
      end
      MEAS_SETTLE: begin
        if (abort) begin
          state_d = MEAS_IDLE;
        end else if (settle_q == '0) begin
          state_d = MEAS_ACCUM;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      MEAS_ACCUM: begin
        if (abort) begin
          state_d = MEAS_IDLE;
        end else if (adc_valid) begin
          tmo_d = TMO_LOAD;
          if (samp_q == CNT_LAST) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
              avg_d[k*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(sum_arr[k] >> LOG2_AVG);
            end
            sat_d   = |hit_vec;
            done_d  = 1'b1;
            state_d = MEAS_IDLE;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end else if (tmo_q == '0) begin
          timeout_d = 1'b1;
          state_d   = MEAS_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      default: state_d = MEAS_IDLE;
    endcase
  end

  // State, counter and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MEAS_IDLE;
      settle_q  <= '0;
      samp_q    <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      sat_q     <= 1'b0;
      avg_q     <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      samp_q    <= samp_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      sat_q     <= sat_d;
      avg_q     <= avg_d;
    end
  end

  assign busy     = (state_q != MEAS_IDLE);
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign sat      = sat_q;
  assign avg_data = avg_q;

endmodule

// File: tb/tb_cal_meas_unit.sv
// Directed bench for cal_meas_unit: a table of averaging vectors run
// back-to-back, plus hand-written timeout, abort, reset and S=0/N=1 sequences.
module tb_cal_meas_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, adc_valid;
  logic [23:0] adc_data;
  logic        busy, done, sat, timeout;
  logic [23:0] avg_data;

  logic        start2, abort2, valid2;
  logic [23:0] data2;
  logic        busy2, done2, sat2, timeout2;
  logic [23:0] avg2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [95:0] ch0;
    logic [95:0] ch1;
    int          gap;
    logic [11:0] exp0;
    logic [11:0] exp1;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  cal_meas_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .busy      (busy),
    .done      (done),
    .avg_data  (avg_data),
    .sat       (sat),
    .timeout   (timeout)
  );

  cal_meas_unit #(
    .SETTLE_CYCLES (0),
    .AVG_SAMPLES   (1)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .abort     (abort2),
    .adc_valid (valid2),
    .adc_data  (data2),
    .busy      (busy2),
    .done      (done2),
    .avg_data  (avg2),
    .sat       (sat2),
    .timeout   (timeout2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [95:0] c0, input logic [95:0] c1, input int g,
                              input logic [11:0] e0, input logic [11:0] e1, input logic es);
    vec_t v;
    v.ch0 = c0; v.ch1 = c1; v.gap = g;
    v.exp0 = e0; v.exp1 = e1; v.exp_sat = es;
    return v;
  endfunction

  // Starts a measurement (caller may be sitting in a done cycle), drives
  // full-scale garbage during settle and invalid gaps, and ends in the done cycle.
  task automatic run_meas(input int idx);
    vec_t v;
    int   j;
    int   c;
    v = vecs[idx];
    start = 1'b1; abort = 1'b0; adc_valid = 1'b0;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d_done_after_start", idx), done, 0);
    for (int s = 0; s < 16; s++) begin
      adc_valid = 1'b1;
      adc_data  = {12'hFFF, 12'hFFF};
      chk($sformatf("v%0d_busy_settle%0d", idx, s), busy, 1);
      chk($sformatf("v%0d_done_settle%0d", idx, s), done, 0);
      tick();
    end
    j = 0;
    c = 0;
    while (j < 8) begin
      if (c % (v.gap + 1) == 0) begin
        adc_valid = 1'b1;
        adc_data  = {v.ch1[j*12 +: 12], v.ch0[j*12 +: 12]};
        j++;
      end else begin
        adc_valid = 1'b0;
        adc_data  = {12'hFFF, 12'hFFF};
      end
      chk($sformatf("v%0d_busy_acc%0d", idx, c), busy, 1);
      chk($sformatf("v%0d_done_acc%0d", idx, c), done, 0);
      tick();
      c++;
    end
    adc_valid = 1'b0;
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_busy_at_done", idx), busy, 0);
    chk($sformatf("v%0d_avg_ch0", idx), avg_data[11:0], v.exp0);
    chk($sformatf("v%0d_avg_ch1", idx), avg_data[23:12], v.exp1);
    chk($sformatf("v%0d_sat", idx), sat, v.exp_sat);
    chk($sformatf("v%0d_timeout", idx), timeout, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at time %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk({12'd114, 12'd112, 12'd110, 12'd108, 12'd106, 12'd104, 12'd102, 12'd100},
                 {8{12'd4095}}, 0, 12'd107, 12'd4095, 1'b1);
    vecs[1] = mk({12'd7, {7{12'd0}}}, {8{12'd20}}, 1, 12'd0, 12'd20, 1'b0);
    vecs[2] = mk({8{12'd4094}}, {12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1},
                 2, 12'd4094, 12'd4, 1'b0);
    vecs[3] = mk({12'd10, 12'd10, 12'd10, 12'd10, 12'd4095, 12'd10, 12'd10, 12'd10},
                 {8{12'd0}}, 1, 12'd520, 12'd0, 1'b1);

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; adc_valid = 1'b0; adc_data = '0;
    start2 = 1'b0; abort2 = 1'b0; valid2 = 1'b0; data2 = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_avg", avg_data, 0);
    chk("rst_sat", sat, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst2_busy", busy2, 0);
    chk("rst2_avg", avg2, 0);
    rst_n = 1'b1;
    tick();

    // S=0, N=1: done two cycles after the start edge with avg = sample
    data2 = {12'd4095, 12'd1234}; valid2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("n1_busy", busy2, 1);
    chk("n1_done_early", done2, 0);
    tick();
    chk("n1_done", done2, 1);
    chk("n1_busy_at_done", busy2, 0);
    chk("n1_avg_ch0", avg2[11:0], 1234);
    chk("n1_avg_ch1", avg2[23:12], 4095);
    chk("n1_sat", sat2, 1);
    valid2 = 1'b0;
    tick();
    chk("n1_done_pulse", done2, 0);

    chk("idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) run_meas(i);
    tick();
    chk("table_done_pulse", done, 0);
    chk("table_busy_idle", busy, 0);

    // Timeout: 256 invalid ACCUM cycles
    start = 1'b1;
    tick();
    start = 1'b0; adc_valid = 1'b0;
    for (int s = 0; s < 16; s++) tick();
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("tmo_wait%0d_timeout", k), timeout, 0);
      chk($sformatf("tmo_wait%0d_busy", k), busy, 1);
      tick();
    end
    chk("tmo_pulse", timeout, 1);
    chk("tmo_no_done", done, 0);
    chk("tmo_busy_fall", busy, 0);
    chk("tmo_avg_ch0_hold", avg_data[11:0], 520);
    chk("tmo_avg_ch1_hold", avg_data[23:12], 0);
    chk("tmo_sat_hold", sat, 1);
    tick();
    chk("tmo_pulse_end", timeout, 0);

    // Abort together with the 8th sample
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 16; s++) tick();
    adc_valid = 1'b1; adc_data = {12'd50, 12'd50};
    for (int j = 0; j < 7; j++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; adc_valid = 1'b0;
    chk("abort8_no_done", done, 0);
    chk("abort8_busy", busy, 0);
    chk("abort8_no_timeout", timeout, 0);
    chk("abort8_avg_hold", avg_data[11:0], 520);
    chk("abort8_sat_hold", sat, 1);
    tick();
    chk("abort8_no_done_late", done, 0);

    // abort + start in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick();
    chk("abort_start_busy2", busy, 0);

    // Reset at sample 4, then a clean run
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 16; s++) tick();
    adc_valid = 1'b1; adc_data = {12'hFFF, 12'hFFF};
    for (int j = 0; j < 3; j++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; adc_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_avg", avg_data, 0);
    chk("midrst_sat", sat, 0);
    chk("midrst_timeout", timeout, 0);
    tick();
    run_meas(2);
    tick();
    chk("post_rst_done_pulse", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cal_meas_unit.md
Name: cal_meas_unit

Overview:
- Measurement front-end between the photodetector ADC interface and the calibration FSM.
- On a start request it waits a thermal-settling interval after a phase/basis change, then averages a fixed number of valid ADC samples on every output channel.
- It returns the per-channel averages with a one-cycle done pulse and a saturation flag.
- The calibration FSM uses it in its SETTLE and SAMPLE states; it is reused for eval readout.

Parameters:
- ADC_WIDTH, 12: ADC sample width, unsigned.
- NUM_OUTPUTS, 2: number of channels.
- SETTLE_CYCLES, 16: settle wait in cycles; 0 is legal.
- AVG_SAMPLES, 8: samples per average; must be a power of two ≥1, checked at elaboration.
- TIMEOUT_CYCLES, 256: maximum cycles in ACCUM without adc_valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a measurement; single-cycle pulse, honoured only in IDLE.
- abort  in  1  cancel the measurement in progress.
- adc_valid  in  1  adc_data is valid this cycle.
- adc_data  in  NUM_OUTPUTS*ADC_WIDTH  channel k at bits [k*ADC_WIDTH +: ADC_WIDTH].
- busy  out  1  high in SETTLE and ACCUM.
- done  out  1  one-cycle pulse; avg_data and sat are updated in the same cycle.
- avg_data  out  NUM_OUTPUTS*ADC_WIDTH  per-channel averages, same packing as adc_data.
- sat  out  1  at least one averaged sample on any channel equalled all-ones.
- timeout  out  1  one-cycle pulse when an ACCUM timeout occurs.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; all counters and accumulators 0; busy, done, avg_data, sat and timeout are all 0.
- States: IDLE, SETTLE, ACCUM.
- IDLE:
  - start=1 and abort=0 at edge T clears the accumulators, sample count and timeout count.
  - Next state is SETTLE, or ACCUM if SETTLE_CYCLES=0.
  - busy=1 from cycle T+1.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles (T+1..T+S); adc_valid is ignored.
  - Then ACCUM.
- ACCUM:
  - Each cycle with adc_valid=1 adds every channel sample to its accumulator (width ADC_WIDTH+log2(AVG_SAMPLES), no overflow possible) and increments the sample count.
  - Any accumulated sample equal to 2^ADC_WIDTH-1 sets an internal sticky sat bit.
  - The timeout counter resets on every valid and increments otherwise.
- Completion:
  - On the edge that accepts the AVG_SAMPLES-th sample: avg_data ← accumulator >> log2(AVG_SAMPLES), truncating, with the final sample included; sat ← sticky bit; done=1 for one cycle; state ← IDLE; busy=0 in that same cycle.
  - With continuous valid, done appears in cycle T+S+N+1.
  - start in the done cycle is accepted, so back-to-back measurements are possible.
- Timeout: the timeout counter reaching TIMEOUT_CYCLES in ACCUM gives timeout=1 for one cycle and state ← IDLE. There is no done, and avg_data/sat hold their previous values.
- Abort: abort=1 in SETTLE or ACCUM gives state ← IDLE on the next edge. There is no done or timeout pulse, and avg_data/sat hold their previous values.
- Simultaneous events:
  - abort with the final sample: abort wins, no done.
  - abort with start in IDLE: start is ignored.
  - start while busy: ignored.
- Reset mid-measurement: identical to the reset case; accumulators are discarded.
- done and timeout are never high in the same cycle.
- The sticky sat bit clears only on start acceptance or reset.

Decomposition:
- Shared package:
  - meas_state_t enum {MEAS_IDLE, MEAS_SETTLE, MEAS_ACCUM}, logic [1:0].
  - Existing ADC_WIDTH, NUM_OUTPUTS, CAL_SETTLE_CYCLES and CAL_AVG_SAMPLES are used as parameter defaults.
  - New constant CAL_MEAS_TIMEOUT = 256.
- Sub-module adc_chan_accum, instantiated NUM_OUTPUTS times:
  - Inputs: clear, accumulate enable, sample.
  - Outputs: sum and saturation-hit flag.
- cal_meas_unit holds the FSM, the settle/sample/timeout counters and the output registers.

Test Plan:
- Nominal average (S=16, N=8, valid every cycle):
  - Stimulus: start at T; ch0 = 100,102,…,114; ch1 = 4095 ×8.
  - Required: busy high T+1..T+24; done only at T+25; avg_data ch0=107, ch1=4095; sat=1.
- Truncation and gaps:
  - Stimulus: ch0 = 0×7 then 7, with valid on alternate cycles.
  - Required: avg ch0=0; sat=0; done one cycle after the 8th valid; valids during SETTLE are not counted.
- Timeout:
  - Stimulus: start, then no adc_valid for 256 cycles after entering ACCUM.
  - Required: timeout pulse exactly one cycle; no done; avg_data unchanged from the previous run; busy falls.
- Abort races:
  - abort in the same cycle as the 8th sample: no done, state IDLE.
  - abort+start in IDLE: busy stays 0.
- Back-to-back and mid-run reset:
  - start in the done cycle: second measurement runs with fresh sums.
  - rst_n=0 at sample 4: all outputs 0 next cycle; a following run produces a correct average.
- SETTLE_CYCLES=0, AVG_SAMPLES=1 configuration:
  - Required: done at T+2 with avg equal to the single sample.
